mlp_layer_sequencer: RTL and testbench

Time-multiplexed sequencer that evaluates a three-layer fully-connected linear network with a single shared multiply-accumulate unit instead of three fully parallel combinational layers. A vector is accepted through a valid/ready handshake, pushed through layers 1, 2 and 3 one product per cycle, and the result is held under a valid/ready handshake until taken. This is the area-reduced alternative to the parallel network. It sits between the input-vector producer and the output-vector consumer.

---
 rtl/mlp_layer_sequencer.sv | 144 ++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer.sv
// Three-layer fully-connected linear network evaluated one product per cycle
// on a single shared multiply-accumulate unit, with valid/ready handshakes on both sides.
module mlp_layer_sequencer #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int FRAC  = 0,
    parameter logic [WIDTH*N*N-1:0] WEIGHTS_MATRIX_FLAT1 = '0,
    parameter logic [WIDTH*N*N-1:0] WEIGHTS_MATRIX_FLAT2 = '0,
    parameter logic [WIDTH*N*N-1:0] WEIGHTS_MATRIX_FLAT3 = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in [0:N-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out [0:N-1],
    output logic                    busy,
    output logic [1:0]              layer_idx
);

    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int WIW  = (N > 1) ? $clog2(N*N) : 1;
    localparam int ACCW = 2*WIDTH + $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);
    localparam logic signed [ACCW-1:0] SAT_MAX = (ACCW'(1) <<< (WIDTH-1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

    state_t                  state, next_state;
    logic signed [WIDTH-1:0] src [0:N-1];
    logic signed [WIDTH-1:0] dst [0:N-1];
    logic signed [WIDTH-1:0] next_dst [0:N-1];
    logic signed [WIDTH-1:0] w_tab [0:3][0:N*N-1];
    logic signed [WIDTH-1:0] weight, row_result;
    logic signed [2*WIDTH-1:0] product;
    logic signed [ACCW-1:0]  acc, sum, shifted;
    logic [IW-1:0]           row, col;
    logic [WIW-1:0]          widx;
    logic [1:0]              layer;
    logic                    row_end, layer_end, accept;

    // Unpack the flat weight parameters into a layer x (row*N+col) lookup table.
    for (genvar k = 0; k < N*N; k++) begin : g_w
        assign w_tab[0][k] = WEIGHTS_MATRIX_FLAT1[WIDTH*k +: WIDTH];
        assign w_tab[1][k] = WEIGHTS_MATRIX_FLAT2[WIDTH*k +: WIDTH];
        assign w_tab[2][k] = WEIGHTS_MATRIX_FLAT3[WIDTH*k +: WIDTH];
        assign w_tab[3][k] = '0;
    end

    assign widx    = WIW'(row) * WIW'(N) + WIW'(col);
    assign weight  = w_tab[layer][widx];
    assign product = src[col] * weight;
    assign sum     = acc + ACCW'(product);
    assign shifted = sum >>> FRAC;

    assign row_result = (shifted > SAT_MAX) ? SAT_MAX[WIDTH-1:0] :
                        (shifted < SAT_MIN) ? SAT_MIN[WIDTH-1:0] :
                                              shifted[WIDTH-1:0];

    assign row_end   = (col == LAST);
    assign layer_end = row_end && (row == LAST);
    assign accept    = (state == IDLE) && in_valid;

    // Last row of a layer is not yet in dst when the layer ends, so merge it in here.
    always_comb begin
        next_dst      = dst;
        next_dst[row] = row_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)                 next_state = COMPUTE;
            COMPUTE: if (layer_end && layer == 2'd2) next_state = HOLD;
            HOLD:    if (out_ready)                next_state = IDLE;
            default:                               next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        layer_idx = 2'd0;
        case (state)
            IDLE:    in_ready = 1'b1;
            COMPUTE: begin
                busy      = 1'b1;
                layer_idx = layer;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src   <= '{default: '0};
            dst   <= '{default: '0};
            out   <= '{default: '0};
            acc   <= '0;
            layer <= 2'd0;
            row   <= '0;
            col   <= '0;
        end else if (accept) begin
            src   <= in;
            acc   <= '0;
            layer <= 2'd0;
            row   <= '0;
            col   <= '0;
        end else if (state == COMPUTE) begin
            if (row_end) begin
                acc      <= '0;
                dst[row] <= row_result;
                col      <= '0;
                row      <= layer_end ? '0 : row + IW'(1);
            end else begin
                acc <= sum;
                col <= col + IW'(1);
            end
            if (layer_end) begin
                src <= next_dst;
                if (layer == 2'd2) begin
                    out   <= next_dst;
                    layer <= 2'd0;
                end else begin
                    layer <= layer + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench: five differently parameterised sequencers share clock, reset and input bus;
// a table of vectors is steered to one of them at a time.
module tb_mlp_layer_sequencer;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int NDUT  = 5;

    typedef logic [WIDTH*N*N-1:0] wflat_t;
    typedef logic [3:0][15:0]      vec4_t;
    typedef struct packed {
        logic [2:0] dut;
        vec4_t      vin;
        vec4_t      vexp;
    } vec_t;

    function automatic wflat_t diag(input logic [15:0] d);
        wflat_t w = '0;
        for (int o = 0; o < N; o++) w[WIDTH*(o*N+o) +: WIDTH] = d;
        return w;
    endfunction

    function automatic wflat_t fill(input logic [15:0] d);
        wflat_t w = '0;
        for (int k = 0; k < N*N; k++) w[WIDTH*k +: WIDTH] = d;
        return w;
    endfunction

    function automatic wflat_t diag_skew();
        wflat_t w = diag(16'h0100);
        w[WIDTH*(0*N+1) +: WIDTH] = 16'h0080;
        return w;
    endfunction

    function automatic vec4_t pack4(input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    localparam wflat_t W_ID1   = diag(16'h0001);
    localparam wflat_t W_TWO   = fill(16'h0002);
    localparam wflat_t W_MAX   = fill(16'h7FFF);
    localparam wflat_t W_ID256 = diag(16'h0100);
    localparam wflat_t W_SKEW  = diag_skew();

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [NDUT-1:0]         in_valid_v;
    wire  [NDUT-1:0]         in_ready_v, out_valid_v, busy_v;
    wire  [NDUT-1:0][1:0]    layer_v;
    logic signed [15:0]      in_vec [0:3];
    logic                    out_ready;
    logic signed [15:0]      o0 [0:3], o1 [0:3], o2 [0:3], o3 [0:3], o4 [0:3];
    logic signed [15:0]      sel_out [0:3];
    logic [2:0]              sel;
    logic                    sel_ready, sel_valid, sel_busy;
    logic [1:0]              sel_layer;

    int checks = 0;
    int fails  = 0;

    mlp_layer_sequencer #(.WIDTH(16), .N(4), .FRAC(0), .WEIGHTS_MATRIX_FLAT1(W_ID1),
        .WEIGHTS_MATRIX_FLAT2(W_ID1), .WEIGHTS_MATRIX_FLAT3(W_ID1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in(in_vec),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out(o0), .busy(busy_v[0]), .layer_idx(layer_v[0]));
    mlp_layer_sequencer #(.WIDTH(16), .N(4), .FRAC(0), .WEIGHTS_MATRIX_FLAT1(W_TWO),
        .WEIGHTS_MATRIX_FLAT2(W_ID1), .WEIGHTS_MATRIX_FLAT3(W_ID1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in(in_vec),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out(o1), .busy(busy_v[1]), .layer_idx(layer_v[1]));
    mlp_layer_sequencer #(.WIDTH(16), .N(4), .FRAC(0), .WEIGHTS_MATRIX_FLAT1(W_MAX),
        .WEIGHTS_MATRIX_FLAT2(W_MAX), .WEIGHTS_MATRIX_FLAT3(W_MAX)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in(in_vec),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .out(o2), .busy(busy_v[2]), .layer_idx(layer_v[2]));
    mlp_layer_sequencer #(.WIDTH(16), .N(4), .FRAC(8), .WEIGHTS_MATRIX_FLAT1(W_ID256),
        .WEIGHTS_MATRIX_FLAT2(W_ID256), .WEIGHTS_MATRIX_FLAT3(W_ID256)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]), .in(in_vec),
        .out_valid(out_valid_v[3]), .out_ready(out_ready), .out(o3), .busy(busy_v[3]), .layer_idx(layer_v[3]));
    mlp_layer_sequencer #(.WIDTH(16), .N(4), .FRAC(8), .WEIGHTS_MATRIX_FLAT1(W_SKEW),
        .WEIGHTS_MATRIX_FLAT2(W_ID256), .WEIGHTS_MATRIX_FLAT3(W_ID256)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]), .in(in_vec),
        .out_valid(out_valid_v[4]), .out_ready(out_ready), .out(o4), .busy(busy_v[4]), .layer_idx(layer_v[4]));

    always_comb begin
        case (sel)
            3'd1:    sel_out = o1;
            3'd2:    sel_out = o2;
            3'd3:    sel_out = o3;
            3'd4:    sel_out = o4;
            default: sel_out = o0;
        endcase
        sel_ready = in_ready_v[sel];
        sel_valid = out_valid_v[sel];
        sel_busy  = busy_v[sel];
        sel_layer = layer_v[sel];
    end

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive_vector(input logic [2:0] d, input vec4_t vin);
        sel = d;
        for (int i = 0; i < 4; i++) in_vec[i] = vin[i];
        in_valid_v    = '0;
        in_valid_v[d] = 1'b1;
    endtask

    // Accept one vector, track latency and layer progress, compare the result, optionally take it.
    task automatic apply_stimulus(input logic [2:0] d, input vec4_t vin, input vec4_t vexp,
                                  input string tag, input bit handshake);
        int cycles;
        @(negedge clk);
        drive_vector(d, vin);
        out_ready = 1'b0;
        #1 check_output({tag, " in_ready"}, 32'(sel_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid_v = '0;
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1)  check_output({tag, " busy"}, 32'(sel_busy), 1);
            if (cycles == 15) check_output({tag, " layer@15"}, 32'(sel_layer), 0);
            if (cycles == 16) check_output({tag, " layer@16"}, 32'(sel_layer), 1);
            if (cycles == 32) check_output({tag, " layer@32"}, 32'(sel_layer), 2);
        end while (!sel_valid && cycles < 200);
        check_output({tag, " latency"}, cycles, 3*N*N);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("%s out[%0d]", tag, i), sel_out[i], $signed(vexp[i]));
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check_output({tag, " out_valid drop"}, 32'(sel_valid), 0);
            check_output({tag, " in_ready rise"}, 32'(sel_ready), 1);
        end
    endtask

    vec_t tbl [0:6];

    initial begin
        tbl[0] = '{dut: 3'd0, vin: pack4(16'd1, -16'sd2, 16'd3, -16'sd4), vexp: pack4(16'd1, -16'sd2, 16'd3, -16'sd4)};
        tbl[1] = '{dut: 3'd1, vin: pack4(16'd1, 16'd2, 16'd3, 16'd4), vexp: pack4(16'd20, 16'd20, 16'd20, 16'd20)};
        tbl[2] = '{dut: 3'd2, vin: pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
                   vexp: pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF)};
        tbl[3] = '{dut: 3'd2, vin: pack4(16'h8001, 16'h8001, 16'h8001, 16'h8001),
                   vexp: pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000)};
        tbl[4] = '{dut: 3'd3, vin: pack4(16'h0180, -16'sh0080, 16'h0000, 16'h7FFF),
                   vexp: pack4(16'h0180, -16'sh0080, 16'h0000, 16'h7FFF)};
        tbl[5] = '{dut: 3'd4, vin: pack4(16'd0, -16'sd1, 16'd0, 16'd0), vexp: pack4(-16'sd1, -16'sd1, 16'd0, 16'd0)};
        tbl[6] = '{dut: 3'd4, vin: pack4(16'h0100, 16'h0200, 16'd0, 16'd0), vexp: pack4(16'h0200, 16'h0200, 16'd0, 16'd0)};

        rst_n      = 1'b0;
        in_valid_v = '0;
        out_ready  = 1'b0;
        sel        = 3'd0;
        for (int i = 0; i < 4; i++) in_vec[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("reset in_ready", 32'(sel_ready), 1);
        check_output("reset out_valid", 32'(sel_valid), 0);
        check_output("reset busy", 32'(sel_busy), 0);
        check_output("reset layer_idx", 32'(sel_layer), 0);
        check_output("reset out[0]", sel_out[0], 0);

        for (int v = 0; v < 7; v++)
            apply_stimulus(tbl[v].dut, tbl[v].vin, tbl[v].vexp, $sformatf("vec%0d", v), 1'b1);

        // Back-pressure: result must hold and a stray in_valid must be ignored.
        apply_stimulus(3'd0, pack4(16'd9, -16'sd1, 16'd2, 16'd7), pack4(16'd9, -16'sd1, 16'd2, 16'd7), "bp", 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) drive_vector(3'd0, pack4(16'd100, 16'd100, 16'd100, 16'd100));
            @(posedge clk);
            @(negedge clk);
            in_valid_v = '0;
            check_output("bp out_valid", 32'(sel_valid), 1);
            check_output("bp in_ready", 32'(sel_ready), 0);
            check_output("bp out[0]", sel_out[0], 9);
            check_output("bp out[3]", sel_out[3], 7);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_output("bp out_valid drop", 32'(sel_valid), 0);
        check_output("bp in_ready rise", 32'(sel_ready), 1);
        check_output("bp busy after", 32'(sel_busy), 0);

        // Reset in the middle of a computation discards it and clears the outputs.
        drive_vector(3'd0, pack4(16'd1, 16'd1, 16'd1, 16'd1));
        @(posedge clk);
        @(negedge clk);
        in_valid_v = '0;
        repeat (24) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst out_valid", 32'(sel_valid), 0);
        check_output("rst busy", 32'(sel_busy), 0);
        check_output("rst layer_idx", 32'(sel_layer), 0);
        for (int i = 0; i < 4; i++) check_output($sformatf("rst out[%0d]", i), sel_out[i], 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_output("rst in_ready after", 32'(sel_ready), 1);
        apply_stimulus(3'd0, pack4(16'd5, 16'd6, 16'd7, 16'd8), pack4(16'd5, 16'd6, 16'd7, 16'd8), "post_rst", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
